min_reduce_int16_ctrl: RTL and testbench
========================================

Name: min_reduce_int16_ctrl

Overview:
Sequential controller that streams COUNT signed 16-bit operands through one shared signed min datapath and produces their running minimum.
- Accepts one operand per cycle over a valid/ready input handshake.
- Holds the accumulator between cycles.
- Presents the final minimum over a valid/ready output handshake.
- Sits between a PIM operand fetch stage and result writeback; it is the scheduler that reuses a single comparator/mux instead of a COUNT-wide tree.

Parameters:
WIDTH, 16, operand/result width in bits, two's-complement signed
COUNT, 8, operands per reduction; legal range 1..65535
IDX_W, $clog2(COUNT) (minimum 1), local; index/counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a reduction; sampled only in IDLE
busy  output  1  high in ACCUM and DONE
in_valid  input  1  operand valid
in_ready  output  1  controller accepts operand
in_data  input  WIDTH  signed operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  signed minimum of the COUNT accepted operands
out_idx  output  IDX_W  position (0-based) of the minimum; present only with MIN_REDUCE_ARGMIN_EN

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; acc=0; cnt=0; busy=0, in_ready=0, out_valid=0, out_data=0, out_idx=0. Asserting rst mid-reduction aborts it; partial result is discarded and no out_valid follows.
- States:
  - IDLE: in_ready=0. start=1 -> ACCUM, cnt<=0.
  - ACCUM: in_ready=1, combinational from state only. An accept is in_valid&&in_ready in a cycle.
    - cnt==0: acc<=in_data.
    - Otherwise: acc<=(acc > in_data, signed) ? in_data : acc.
    - cnt increments on each accept. Accept with cnt==COUNT-1 -> DONE.
  - DONE: out_valid=1, out_data=acc; in_ready=0. out_valid&&out_ready -> IDLE next cycle. Result is held stable while out_ready=0.
- Comparison is strictly signed greater-than. Ties keep the earlier operand, so the earliest index wins.
- Throughput: one operand per cycle while in_valid stays high. Latency: out_valid rises the cycle after the last accept.
- start is ignored in ACCUM and DONE. start and out handshake in the same DONE cycle: the start is dropped; a new start must come in IDLE.
- in_valid gaps in ACCUM simply stall; there is no timeout.
- COUNT==1: the first accept goes directly to DONE; the result equals that operand.
- Extremes: -32768 and 32767 compare correctly. No overflow is possible because there is no arithmetic beyond compare/select.
- cnt never wraps: it resets to 0 on start and cannot exceed COUNT-1.

Optional Feature:
MIN_REDUCE_ARGMIN_EN
- Defined: the out_idx port exists. An idx register is loaded with cnt whenever acc is replaced, including cnt==0. out_idx is valid with out_valid and resets to 0.
- Undefined: no out_idx port and no idx register. All other behaviour is identical.

Decomposition:
- Package min_reduce_pkg: state enum (IDLE, ACCUM, DONE, 2-bit encoding 0/1/2), default WIDTH and COUNT constants.
- One natural sub-module, min_sel_int: combinational, WIDTH-parameterized, signed A>B compare. It outputs the selected minimum (B if A>B else A) plus a take_b flag used for argmin tracking. The controller instantiates it once with A=acc, B=in_data.

Test Plan:
- COUNT=8, operands 5,-3,7,-3,0,12,-100,4 streamed back-to-back -> out_valid 1 cycle after 8th accept, out_data=-100, out_idx=6.
- Operands -32768,32767,0,... then all 32767 -> out_data=-32768, out_idx=0. Also all operands equal 9 -> out_data=9, out_idx=0 (tie keeps earliest).
- in_valid toggled randomly and out_ready held low 5 cycles -> result identical to back-to-back case; out_data/out_valid stable while stalled; in_ready=0 in DONE.
- rst pulsed after 3 accepts -> all outputs 0 immediately. A new start with 8 fresh operands -> correct min of the new set only.
- start pulsed during ACCUM and DONE -> no effect. COUNT=1 build, operand -7 -> out_valid next cycle, out_data=-7.
- Build without MIN_REDUCE_ARGMIN_EN -> no out_idx port; scenario 1 still gives out_data=-100.

Source files
------------

// File: rtl/min_reduce_pkg.sv
// Shared types and default sizing for the signed-min reduction controller.
package min_reduce_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_COUNT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/min_sel_int.sv
// Combinational signed min select: returns b when a > b, else a (ties keep a).
module min_sel_int #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] min_o,
  output logic                    take_b_o
);
  assign take_b_o = a_i > b_i;
  assign min_o    = take_b_o ? b_i : a_i;
endmodule

// File: rtl/min_reduce_int16_ctrl.sv
// Streams COUNT signed operands through one shared min comparator and returns the minimum.
// Define MIN_REDUCE_ARGMIN_EN to add the out_idx port (position of the minimum).
module min_reduce_int16_ctrl
  import min_reduce_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int COUNT = DEF_COUNT,
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
`ifdef MIN_REDUCE_ARGMIN_EN
  ,
  output logic [IDX_W-1:0]        out_idx
`endif
);
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] sel_min;
  logic                    take_b, accept, last, replace;

  min_sel_int #(.WIDTH(WIDTH)) u_sel (
    .a_i      (acc_q),
    .b_i      (in_data),
    .min_o    (sel_min),
    .take_b_o (take_b)
  );

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == IDX_W'(COUNT - 1));
  // The first operand of a reduction seeds the accumulator unconditionally.
  assign replace   = (cnt_q == '0) || take_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        cnt_d   = '0;
      end
      ACCUM: if (accept) begin
        acc_d = replace ? in_data : sel_min;
        if (last) state_d = DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

`ifdef MIN_REDUCE_ARGMIN_EN
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (accept && replace) idx_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign out_idx = idx_q;
`endif
endmodule

// File: tb/tb_min_reduce_int16_ctrl.sv
// Scoreboard bench for min_reduce_int16_ctrl: randomized and directed reductions vs a reference min.
module tb_min_reduce_int16_ctrl;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                start, in_valid, out_ready;
  logic signed [W-1:0] in_data;
  logic                busy, in_ready, out_valid;
  logic signed [W-1:0] out_data;
  logic [IW-1:0]       out_idx;

  logic                start1, in_valid1, out_ready1;
  logic signed [W-1:0] in_data1;
  logic                busy1, in_ready1, out_valid1;
  logic signed [W-1:0] out_data1;
  logic [0:0]          out_idx1;

  min_reduce_int16_ctrl #(.WIDTH(W), .COUNT(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MIN_REDUCE_ARGMIN_EN
    , .out_idx(out_idx)
`endif
  );

  min_reduce_int16_ctrl #(.WIDTH(W), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
`ifdef MIN_REDUCE_ARGMIN_EN
    , .out_idx(out_idx1)
`endif
  );

`ifndef MIN_REDUCE_ARGMIN_EN
  assign out_idx  = '0;
  assign out_idx1 = '0;
`endif

  typedef struct {
    logic signed [W-1:0] d;
    int                  idx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: smallest value, earliest position on ties.
  function automatic exp_t ref_min(input int v[$]);
    exp_t e;
    int   m, p;
    m = v[0];
    p = 0;
    for (int i = 1; i < v.size(); i++)
      if (v[i] < m) begin
        m = v[i];
        p = i;
      end
    e.d   = W'(m);
    e.idx = p;
    return e;
  endfunction

  logic signed [W-1:0] prev_d;
  logic                prev_hold = 1'b0;

  always @(negedge clk) begin
    if (rst) prev_hold = 1'b0;
    else if (out_valid) begin
      chk("in_ready_done", longint'(in_ready), 0);
      if (prev_hold) chk("hold_data", longint'(out_data), longint'(prev_d));
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got out_data %0d with no expected result", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", longint'(out_data), longint'(e.d));
`ifdef MIN_REDUCE_ARGMIN_EN
          chk("out_idx", longint'(out_idx), longint'(e.idx));
`endif
        end
      end
      prev_hold = !out_ready;
      prev_d    = out_data;
    end else prev_hold = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reduce(input int v[$], input bit gaps, input int stall, input bit poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_accum", longint'(busy), 1);
    for (int i = 0; i < N; i++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          in_valid = 1'b0;
          tick();
        end
      in_valid = 1'b1;
      in_data  = W'(v[i]);
      start    = poke && (i == 2);
      chk("in_ready_accum", longint'(in_ready), 1);
      chk("no_early_valid", longint'(out_valid), 0);
      if (i == N - 1) sb.push_back(ref_min(v));
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("latency", longint'(out_valid), 1);
    for (int s = 0; s < stall; s++) begin
      start = poke;
      tick();
    end
    start     = poke;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("valid_drop", longint'(out_valid), 0);
    chk("busy_idle", longint'(busy), 0);
    tick();
    chk("start_dropped", longint'(busy), 0);
  endtask

  initial begin
    int v[$];
    rst = 1'b0; start = 0; in_valid = 0; out_ready = 0; in_data = '0;
    start1 = 0; in_valid1 = 0; out_ready1 = 0; in_data1 = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_idx", longint'(out_idx), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    v = '{5, -3, 7, -3, 0, 12, -100, 4};
    reduce(v, 0, 0, 0);
    v = '{-32768, 32767, 0, 32767, 32767, 32767, 32767, 32767};
    reduce(v, 0, 0, 0);
    v = '{9, 9, 9, 9, 9, 9, 9, 9};
    reduce(v, 0, 0, 0);
    v = '{5, -3, 7, -3, 0, 12, -100, 4};
    reduce(v, 1, 5, 1);
    v = '{32767, 100, -5, 32767, -32768, 3, -32768, 0};
    reduce(v, 1, 2, 0);

    // Abort after three accepts; nothing from this set may surface.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'(-1000 - i); tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_in_ready", longint'(in_ready), 0);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_out_data", longint'(out_data), 0);
    chk("abort_out_idx", longint'(out_idx), 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("abort_no_valid", longint'(out_valid), 0);
    v = '{40, 22, 31, 22, 99, 25, 60, 23};
    reduce(v, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      v.delete();
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       v.push_back(-32768);
          1:       v.push_back(32767);
          2:       v.push_back($urandom_range(0, 7) - 4);
          default: v.push_back(int'($urandom_range(0, 65535)) - 32768);
        endcase
      end
      reduce(v, 1, $urandom_range(0, 4), r[0]);
    end

    // COUNT=1 instance: the first accept completes the reduction.
    start1 = 1'b1; tick(); start1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = -16'sd7;
    chk("c1_in_ready", longint'(in_ready1), 1);
    tick();
    in_valid1 = 1'b0;
    chk("c1_out_valid", longint'(out_valid1), 1);
    chk("c1_out_data", longint'(out_data1), -7);
    chk("c1_out_idx", longint'(out_idx1), 0);
    out_ready1 = 1'b1; tick(); out_ready1 = 1'b0;
    chk("c1_valid_drop", longint'(out_valid1), 0);

    tick(); tick();
    chk("sb_drained", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
